music_sequencer: RTL and testbench
==================================

# music_sequencer

Playback controller for the music sheet lookup. It steps the sheet index, latches each entry's note (half-period in clock cycles) and duration (in eighth-note units), and times both. It generates the square-wave speaker output and stops or loops at the end of the song. It sits between the board-level start/stop/pause controls and the combinational sheet ROM, and drives the speaker pin directly.

## Interface
Parameters:
- EIGHTH_CYCLES, 12500000: clock cycles per duration unit (one eighth note); must be ≥1.
- LAST_INDEX, 44: last valid sheet index; entries above it are never played.
- LOOP, 0: 1 = restart at index 0 after LAST_INDEX; 0 = stop in DONE.

Ports:
- clk  in  1  system clock, rising-edge.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  level/pulse; begins playback from IDLE or DONE.
- stop  in  1  synchronous abort to IDLE; priority over start and pause.
- pause  in  1  freezes playback while high.
- note  in  20  half-period count from sheet for current number; value ≤1 = rest.
- duration  in  5  length of current entry in eighth units.
- number  out  10  registered sheet index.
- speaker  out  1  square-wave audio output.
- playing  out  1  high in LOAD or PLAY.
- done  out  1  high in DONE.

## Operation
- Sheet is combinational: note/duration are valid in the same cycle as number.
- States: IDLE, LOAD, PLAY, DONE.
- IDLE: number=0, speaker=0. start=1 → LOAD.
- LOAD (exactly 1 cycle): note_q←note, units←(duration==0 ? 1 : duration), eighth_cnt←0, tone_cnt←0, speaker←0. → PLAY.
- PLAY, pause=0:
  - Tone: if note_q ≥ 2, tone_cnt counts 0..note_q−1. At note_q−1 it wraps to 0 and speaker toggles. If note_q ≤ 1, speaker=0 (rest).
  - Duration: eighth_cnt counts 0..EIGHTH_CYCLES−1. At the terminal count, units decrements.
  - End of entry: the terminal eighth count with units==1.
    - If number<LAST_INDEX: number←number+1, → LOAD.
    - Else if LOOP=1: number←0, → LOAD.
    - Else: → DONE.
- PLAY, pause=1: tone_cnt, eighth_cnt, units and number frozen; speaker forced 0. On release, counting resumes from the frozen values. The tone phase restarts from speaker=0.
- DONE: speaker=0, number holds LAST_INDEX, done=1. start=1 → number←0, → LOAD.
- stop=1 in any state: next cycle state=IDLE, number=0, speaker=0, all counters 0.
- Priority: stop > start and pause. start is ignored in LOAD/PLAY. pause is ignored outside PLAY.
- Counter widths:
  - eighth_cnt: $clog2(EIGHTH_CYCLES) bits, minimum 1.
  - tone_cnt: 20 bits.
  - units: 5 bits.
  - No overflow is possible.

## Timing
- Reset values: state=IDLE, number=0, speaker=0, playing=0, done=0, all counters 0.
- start sampled high in IDLE → playing=1 on the next edge (LOAD). PLAY begins the following cycle.
- Each entry occupies 1 LOAD cycle plus units×EIGHTH_CYCLES PLAY cycles, excluding paused cycles.
- number updates on the same edge that enters LOAD. The new note/duration are latched at the end of that LOAD cycle.
- First speaker toggle: note_q PLAY cycles after entering PLAY. Subsequent toggles every note_q cycles, giving period 2×note_q.
- Song end with LOOP=0: done=1 and playing=0 on the edge after the final PLAY cycle.
- rst_n low mid-playback: all outputs return to reset values immediately, independent of clk.

## Test plan
Use EIGHTH_CYCLES=10, LAST_INDEX=2, LOOP=0, and a stub sheet: idx0 {4,2}, idx1 {1,1}, idx2 {3,0}.
- Reset, then start pulse → number=0, LOAD for 1 cycle, then 20 PLAY cycles.
  - Speaker toggles at PLAY cycles 4, 8, 12, 16, 20 (period 8 cycles).
  - number=1 on the next edge.
- Rest entry idx1 → speaker=0 for all 10 PLAY cycles, then number=2.
- Zero-duration idx2 → treated as 1 unit: 10 PLAY cycles, speaker toggling every 3 cycles. Then done=1, playing=0, number=2, speaker=0.
- Pause raised for 7 cycles at PLAY cycle 5 of idx0:
  - speaker=0 and counters frozen during the pause.
  - The entry ends 27 cycles after entering PLAY.
- stop asserted mid-idx1 together with start:
  - Next cycle state=IDLE, number=0, speaker=0, playing=0.
  - A later start replays from idx0.
- LOOP=1: after idx2 completes, number=0 and LOAD follow, and done never asserts.
- rst_n dropped asynchronously mid-idx0 → number, speaker, playing, done go to 0 without a clock edge.

Source files
------------

// File: rtl/music_sequencer_if.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | music_sequencer_if : control, sheet-lookup and speaker signal group |
// | Revision: 1.0                                                       |
// +--------------------------------------------------------------------+
interface music_sequencer_if;
  logic        start;
  logic        stop;
  logic        pause;
  logic [19:0] note;
  logic [4:0]  duration;
  logic [9:0]  number;
  logic        speaker;
  logic        playing;
  logic        done;

  modport master (
    output start, stop, pause, note, duration,
    input  number, speaker, playing, done
  );

  modport slave (
    input  start, stop, pause, note, duration,
    output number, speaker, playing, done
  );
endinterface
`default_nettype wire

// File: rtl/music_sequencer.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | music_sequencer : steps the sheet index, times notes, drives speaker|
// | Revision: 1.0                                                       |
// +--------------------------------------------------------------------+
module music_sequencer #(
  parameter int EIGHTH_CYCLES = 12500000,
  parameter int LAST_INDEX    = 44,
  parameter bit LOOP          = 1'b0
) (
  input  logic              clk,
  input  logic              rst_n,
  music_sequencer_if.slave  bus
);

  localparam int              EW          = (EIGHTH_CYCLES > 1) ? $clog2(EIGHTH_CYCLES) : 1;
  localparam logic [EW-1:0]   EIGHTH_LAST = EW'(EIGHTH_CYCLES - 1);
  localparam logic [9:0]      LAST_NUM    = 10'(LAST_INDEX);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_PLAY, S_DONE} state_t;

  state_t        state_q;
  logic [9:0]    number_q;
  logic          speaker_q;
  logic          playing_q;
  logic          done_q;
  logic [19:0]   note_q;
  logic [4:0]    units_q;
  logic [EW-1:0] eighth_q;
  logic [19:0]   tone_q;

  logic [4:0]    units_d;

  // A zero-length entry still plays for one eighth.
  assign units_d = (bus.duration == 5'd0) ? 5'd1 : bus.duration;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      number_q  <= 10'd0;
      speaker_q <= 1'b0;
      playing_q <= 1'b0;
      done_q    <= 1'b0;
      note_q    <= 20'd0;
      units_q   <= 5'd0;
      eighth_q  <= '0;
      tone_q    <= 20'd0;
    end else if (bus.stop) begin
      state_q   <= S_IDLE;
      number_q  <= 10'd0;
      speaker_q <= 1'b0;
      playing_q <= 1'b0;
      done_q    <= 1'b0;
      note_q    <= 20'd0;
      units_q   <= 5'd0;
      eighth_q  <= '0;
      tone_q    <= 20'd0;
    end else begin
      case (state_q)
        S_IDLE: begin
          speaker_q <= 1'b0;
          if (bus.start) begin
            state_q   <= S_LOAD;
            playing_q <= 1'b1;
          end
        end

        S_LOAD: begin
          note_q    <= bus.note;
          units_q   <= units_d;
          eighth_q  <= '0;
          tone_q    <= 20'd0;
          speaker_q <= 1'b0;
          state_q   <= S_PLAY;
        end

        S_PLAY: begin
          if (bus.pause) begin
            speaker_q <= 1'b0;
          end else begin
            if (note_q >= 20'd2) begin
              if (tone_q == note_q - 20'd1) begin
                tone_q    <= 20'd0;
                speaker_q <= ~speaker_q;
              end else begin
                tone_q <= tone_q + 20'd1;
              end
            end else begin
              speaker_q <= 1'b0;
            end

            if (eighth_q == EIGHTH_LAST) begin
              eighth_q <= '0;
              units_q  <= units_q - 5'd1;
              if (units_q == 5'd1) begin
                if (number_q < LAST_NUM) begin
                  number_q <= number_q + 10'd1;
                  state_q  <= S_LOAD;
                end else if (LOOP) begin
                  number_q <= 10'd0;
                  state_q  <= S_LOAD;
                end else begin
                  state_q   <= S_DONE;
                  playing_q <= 1'b0;
                  done_q    <= 1'b1;
                  speaker_q <= 1'b0;
                end
              end
            end else begin
              eighth_q <= eighth_q + 1'b1;
            end
          end
        end

        S_DONE: begin
          speaker_q <= 1'b0;
          if (bus.start) begin
            number_q  <= 10'd0;
            state_q   <= S_LOAD;
            playing_q <= 1'b1;
            done_q    <= 1'b0;
          end
        end

        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign bus.number  = number_q;
  assign bus.speaker = speaker_q;
  assign bus.playing = playing_q;
  assign bus.done    = done_q;

endmodule
`default_nettype wire

// File: tb/tb_music_sequencer.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_music_sequencer : stub-sheet bench, LOOP=0 and LOOP=1 instances  |
// | Revision: 1.0                                                       |
// +--------------------------------------------------------------------+
module tb_music_sequencer;

  localparam int E    = 10;
  localparam int LAST = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0;
  logic stop  = 1'b0;
  logic pause = 1'b0;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  function automatic logic [19:0] sheet_note(input logic [9:0] idx);
    case (idx)
      10'd0:   return 20'd4;
      10'd1:   return 20'd1;
      10'd2:   return 20'd3;
      default: return 20'd0;
    endcase
  endfunction

  function automatic logic [4:0] sheet_dur(input logic [9:0] idx);
    case (idx)
      10'd0:   return 5'd2;
      10'd1:   return 5'd1;
      default: return 5'd0;
    endcase
  endfunction

  music_sequencer_if if0 ();
  music_sequencer_if if1 ();

  assign if0.start    = start;
  assign if0.stop     = stop;
  assign if0.pause    = pause;
  assign if0.note     = sheet_note(if0.number);
  assign if0.duration = sheet_dur(if0.number);
  assign if1.start    = start;
  assign if1.stop     = stop;
  assign if1.pause    = pause;
  assign if1.note     = sheet_note(if1.number);
  assign if1.duration = sheet_dur(if1.number);

  music_sequencer #(.EIGHTH_CYCLES(E), .LAST_INDEX(LAST), .LOOP(1'b0)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .bus(if0)
  );
  music_sequencer #(.EIGHTH_CYCLES(E), .LAST_INDEX(LAST), .LOOP(1'b1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .bus(if1)
  );

  // Model: an entry lasts max(dur,1)*E active cycles; the speaker flips whenever
  // the active count reaches a multiple of the note, and is 0 while paused.
  localparam int M_IDLE = 0, M_LOAD = 1, M_PLAY = 2, M_DONE = 3;
  int m_state [2];
  int m_num   [2];
  int m_spk   [2];
  int m_note  [2];
  int m_len   [2];
  int m_act   [2];

  always @(posedge clk or negedge rst_n) begin
    for (int d = 0; d < 2; d++) begin
      if (!rst_n || stop) begin
        m_state[d] = M_IDLE; m_num[d] = 0; m_spk[d] = 0;
        m_note[d] = 0; m_len[d] = 0; m_act[d] = 0;
      end else begin
        case (m_state[d])
          M_IDLE: if (start) m_state[d] = M_LOAD;
          M_DONE: if (start) begin m_state[d] = M_LOAD; m_num[d] = 0; end
          M_LOAD: begin
            m_note[d]  = int'(sheet_note(10'(m_num[d])));
            m_len[d]   = ((sheet_dur(10'(m_num[d])) == 0) ? 1 : int'(sheet_dur(10'(m_num[d])))) * E;
            m_act[d]   = 0;
            m_spk[d]   = 0;
            m_state[d] = M_PLAY;
          end
          default: begin
            if (pause) begin
              m_spk[d] = 0;
            end else begin
              m_act[d]++;
              if (m_note[d] < 2) m_spk[d] = 0;
              else if (m_act[d] % m_note[d] == 0) m_spk[d] = 1 - m_spk[d];
              if (m_act[d] == m_len[d]) begin
                if (m_num[d] < LAST) begin
                  m_num[d]++; m_state[d] = M_LOAD;
                end else if (d == 1) begin
                  m_num[d] = 0; m_state[d] = M_LOAD;
                end else begin
                  m_state[d] = M_DONE; m_spk[d] = 0;
                end
              end
            end
          end
        endcase
      end
    end
  end

  task automatic cmp(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
    end
  endtask

  always @(posedge clk) begin
    #1;
    if (rst_n) begin
      cmp("dut0.number",  int'(if0.number),  m_num[0]);
      cmp("dut0.speaker", int'(if0.speaker), m_spk[0]);
      cmp("dut0.playing", int'(if0.playing), int'(m_state[0] == M_LOAD || m_state[0] == M_PLAY));
      cmp("dut0.done",    int'(if0.done),    int'(m_state[0] == M_DONE));
      cmp("dut1.number",  int'(if1.number),  m_num[1]);
      cmp("dut1.speaker", int'(if1.speaker), m_spk[1]);
      cmp("dut1.playing", int'(if1.playing), int'(m_state[1] == M_LOAD || m_state[1] == M_PLAY));
      cmp("dut1.done",    int'(if1.done),    int'(m_state[1] == M_DONE));
    end
  end

  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    step(3);
    rst_n = 1'b1;
    step(1);
    cmp("reset.number",  int'(if0.number),  0);
    cmp("reset.speaker", int'(if0.speaker), 0);
    cmp("reset.playing", int'(if0.playing), 0);
    cmp("reset.done",    int'(if0.done),    0);

    // Full song: LOAD at t=0, idx0 PLAY t1..t20, idx1 LOAD t21, idx2 LOAD t32, DONE t43.
    start = 1'b1;
    step(1);
    start = 1'b0;
    cmp("song.load_playing", int'(if0.playing), 1);
    cmp("song.load_number",  int'(if0.number),  0);
    step(4);
    cmp("song.spk_t4", int'(if0.speaker), 0);
    step(1);
    cmp("song.spk_t5", int'(if0.speaker), 1);
    step(15);
    cmp("song.num_t20", int'(if0.number), 0);
    step(1);
    cmp("song.num_t21", int'(if0.number), 1);
    step(11);
    cmp("song.num_t32", int'(if0.number), 2);
    step(10);
    cmp("song.done_t42", int'(if0.done), 0);
    step(1);
    cmp("song.done_t43",    int'(if0.done),    1);
    cmp("song.playing_t43", int'(if0.playing), 0);
    cmp("song.number_t43",  int'(if0.number),  2);
    cmp("song.speaker_t43", int'(if0.speaker), 0);
    cmp("loop.number_t43",  int'(if1.number),  0);
    cmp("loop.playing_t43", int'(if1.playing), 1);
    cmp("loop.done_t43",    int'(if1.done),    0);

    // Pause for 7 cycles starting at PLAY cycle 5 of idx0.
    start = 1'b1;
    step(1);
    start = 1'b0;
    step(5);
    pause = 1'b1;
    step(2);
    cmp("pause.speaker", int'(if0.speaker), 0);
    step(5);
    pause = 1'b0;
    step(15);
    cmp("pause.num_f27", int'(if0.number), 0);
    step(1);
    cmp("pause.num_f28", int'(if0.number), 1);

    // stop together with start mid-idx1.
    step(4);
    stop = 1'b1;
    start = 1'b1;
    step(1);
    stop = 1'b0;
    start = 1'b0;
    cmp("stop.number",  int'(if0.number),  0);
    cmp("stop.playing", int'(if0.playing), 0);
    cmp("stop.speaker", int'(if0.speaker), 0);
    step(2);
    start = 1'b1;
    step(1);
    start = 1'b0;
    cmp("restart.playing", int'(if0.playing), 1);
    cmp("restart.number",  int'(if0.number),  0);

    for (int i = 0; i < 3000; i++) begin
      start = ($urandom_range(0, 15) == 0);
      stop  = ($urandom_range(0, 199) == 0);
      if ($urandom_range(0, 9) == 0) pause = ~pause;
      step(1);
    end
    start = 1'b0;
    stop  = 1'b0;
    pause = 1'b0;

    // Asynchronous reset in the middle of idx0.
    stop = 1'b1;
    step(1);
    stop = 1'b0;
    start = 1'b1;
    step(1);
    start = 1'b0;
    step(6);
    #2;
    rst_n = 1'b0;
    #1;
    cmp("areset.number",  int'(if0.number),  0);
    cmp("areset.speaker", int'(if0.speaker), 0);
    cmp("areset.playing", int'(if0.playing), 0);
    cmp("areset.done",    int'(if0.done),    0);
    cmp("areset.playing1", int'(if1.playing), 0);
    step(2);
    rst_n = 1'b1;
    step(3);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
